// File: rtl/bsg_cgol_pkg.sv
// Shared types and sizing helpers for the CGoL accelerator input stage.
package bsg_cgol_pkg;

  typedef enum logic [1:0] {
    eFRAMES = 2'd0,
    eBOARD  = 2'd1,
    eFULL   = 2'd2
  } deser_state_e;

  // Width of a counter or index that must hold values 0..n-1, never narrower than one bit.
  function automatic int safe_clog2(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  function automatic int cgol_words(input int board_width, input int data_width);
    return (board_width * board_width + data_width - 1) / data_width;
  endfunction

endpackage

// File: rtl/bsg_cgol_word_counter.sv
// Board-word index: clears when a new descriptor starts, counts accepted words and
// saturates at the last word so it never wraps.
module bsg_cgol_word_counter #(
  parameter int words_p = 1,
  parameter int width_p = 1
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic               clear_i,
  input  logic               up_i,
  output logic [width_p-1:0] count_o,
  output logic               is_last_o
);

  localparam logic [width_p-1:0] last_lp = width_p'(words_p - 1);

  logic [width_p-1:0] count_d, count_q;

  // Next count: clear has priority over increment.
  always_comb begin
    count_d = count_q;
    if (clear_i) begin
      count_d = {width_p{1'b0}};
    end else if (up_i && !is_last_o) begin
      count_d = count_q + width_p'(1);
    end else begin
      count_d = count_q;
    end
  end

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      count_q <= {width_p{1'b0}};
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o   = count_q;
  assign is_last_o = (count_q == last_lp);

endmodule

// File: rtl/bsg_cgol_input_deser.sv
// Deserialises one frames word plus the board words into a single descriptor.
// Optional BSG_CGOL_DESER_BYPASS_EN lets the next frames word be taken during handoff.
module bsg_cgol_input_deser
  import bsg_cgol_pkg::*;
#(
  parameter  int board_width_p     = 8,
  parameter  int max_game_length_p = 1024,
  parameter  int data_width_p      = 64,
  localparam int board_bits_lp     = board_width_p * board_width_p,
  localparam int game_len_width_lp = safe_clog2(max_game_length_p)
) (
  input  logic                         clk_i,
  input  logic                         reset_i,
  input  logic [data_width_p-1:0]      data_i,
  input  logic                         v_i,
  output logic                         ready_o,
  output logic [board_bits_lp-1:0]     board_o,
  output logic [game_len_width_lp-1:0] frames_o,
  output logic                         v_o,
  input  logic                         ready_i
);

  localparam int words_lp     = cgol_words(board_width_p, data_width_p);
  localparam int cnt_width_lp = safe_clog2(words_lp);

  deser_state_e                 state_d, state_q;
  logic [game_len_width_lp-1:0] frames_d, frames_q;
  logic [board_bits_lp-1:0]     board_d, board_q;
  logic                         v_d, v_q;
  logic                         link_xfer_s;
  logic                         cnt_clear_s, cnt_up_s;
  logic [cnt_width_lp-1:0]      cnt_s;
  logic                         cnt_last_s;

  bsg_cgol_word_counter #(
    .words_p (words_lp),
    .width_p (cnt_width_lp)
  ) word_counter (
    .clk_i     (clk_i),
    .reset_i   (reset_i),
    .clear_i   (cnt_clear_s),
    .up_i      (cnt_up_s),
    .count_o   (cnt_s),
    .is_last_o (cnt_last_s)
  );

  // Link readiness depends only on state (and downstream ready in bypass builds).
  always_comb begin
    ready_o = 1'b1;
    case (state_q)
      eFRAMES: ready_o = 1'b1;
      eBOARD:  ready_o = 1'b1;
`ifdef BSG_CGOL_DESER_BYPASS_EN
      eFULL:   ready_o = ready_i;
`else
      eFULL:   ready_o = 1'b0;
`endif
      default: ready_o = 1'b1;
    endcase
  end

  assign link_xfer_s = v_i & ready_o;

  // Next state, frames capture and board-word placement.
  always_comb begin
    state_d     = state_q;
    frames_d    = frames_q;
    board_d     = board_q;
    cnt_clear_s = 1'b0;
    cnt_up_s    = 1'b0;
    case (state_q)
      eFRAMES: begin
        if (link_xfer_s) begin
          frames_d    = data_i[game_len_width_lp-1:0];
          cnt_clear_s = 1'b1;
          state_d     = eBOARD;
        end else begin
          state_d = eFRAMES;
        end
      end
      eBOARD: begin
        if (link_xfer_s) begin
          // Bits beyond the board edge in the final word have no destination and drop out.
          for (int i = 0; i < board_bits_lp; i++) begin
            if (cnt_s == cnt_width_lp'(i / data_width_p)) begin
              board_d[i] = data_i[i % data_width_p];
            end else begin
              board_d[i] = board_q[i];
            end
          end
          if (cnt_last_s) begin
            state_d = eFULL;
          end else begin
            cnt_up_s = 1'b1;
            state_d  = eBOARD;
          end
        end else begin
          state_d = eBOARD;
        end
      end
      eFULL: begin
        if (ready_i) begin
          state_d = eFRAMES;
          if (link_xfer_s) begin
            frames_d    = data_i[game_len_width_lp-1:0];
            cnt_clear_s = 1'b1;
            state_d     = eBOARD;
          end else begin
            frames_d = frames_q;
          end
        end else begin
          state_d = eFULL;
        end
      end
      default: begin
        state_d = eFRAMES;
      end
    endcase
    v_d = (state_d == eFULL);
  end

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      state_q  <= eFRAMES;
      frames_q <= {game_len_width_lp{1'b0}};
      board_q  <= {board_bits_lp{1'b0}};
      v_q      <= 1'b0;
    end else begin
      state_q  <= state_d;
      frames_q <= frames_d;
      board_q  <= board_d;
      v_q      <= v_d;
    end
  end

  assign v_o      = v_q;
  assign board_o  = board_q;
  assign frames_o = frames_q;

endmodule

// File: tb/tb_bsg_cgol_input_deser.sv
// Directed bench for bsg_cgol_input_deser (4x4 board, 8-bit link, 4-bit frames).
module tb_bsg_cgol_input_deser;

  logic        clk_i = 1'b0;
  logic        reset_i;
  logic [7:0]  data_i;
  logic        v_i;
  logic        ready_o;
  logic [15:0] board_o;
  logic [3:0]  frames_o;
  logic        v_o;
  logic        ready_i;

  int vectors     = 0;
  int miscompares = 0;

  bsg_cgol_input_deser #(
    .board_width_p     (4),
    .max_game_length_p (16),
    .data_width_p      (8)
  ) dut (
    .clk_i    (clk_i),
    .reset_i  (reset_i),
    .data_i   (data_i),
    .v_i      (v_i),
    .ready_o  (ready_o),
    .board_o  (board_o),
    .frames_o (frames_o),
    .v_o      (v_o),
    .ready_i  (ready_i)
  );

  always #5 clk_i = ~clk_i;

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk_i);
    #1;
  endtask

  task automatic send(input logic [7:0] d);
    v_i    = 1'b1;
    data_i = d;
    cyc();
    v_i    = 1'b0;
  endtask

  task automatic idle(input int n);
    v_i = 1'b0;
    for (int k = 0; k < n; k++) cyc();
  endtask

  task automatic handoff();
    ready_i = 1'b1;
    cyc();
    ready_i = 1'b0;
  endtask

  initial begin
    reset_i = 1'b0;
    v_i     = 1'b0;
    ready_i = 1'b0;
    data_i  = 8'h00;
    cyc();
    cyc();
    check("rst_ready", 32'(ready_o), 32'h1);
    check("rst_v", 32'(v_o), 32'h0);
    check("rst_board", 32'(board_o), 32'h0);
    check("rst_frames", 32'(frames_o), 32'h0);
    reset_i = 1'b1;
    cyc();

    // Back-to-back message, consumer not ready.
    send(8'h05);
    send(8'hA5);
    check("t1_mid_v", 32'(v_o), 32'h0);
    check("t1_mid_ready", 32'(ready_o), 32'h1);
    send(8'h3C);
    check("t1_v", 32'(v_o), 32'h1);
    check("t1_board", 32'(board_o), 32'h3CA5);
    check("t1_frames", 32'(frames_o), 32'h5);
    check("t1_ready_held", 32'(ready_o), 32'h0);
    v_i = 1'b1;
    data_i = 8'hFF;
    cyc();
    cyc();
    cyc();
    v_i = 1'b0;
    check("t1_hold_v", 32'(v_o), 32'h1);
    check("t1_hold_board", 32'(board_o), 32'h3CA5);
    check("t1_hold_frames", 32'(frames_o), 32'h5);

    // One-cycle handoff.
    handoff();
    check("t3_v", 32'(v_o), 32'h0);
    check("t3_ready", 32'(ready_o), 32'h1);

    // Frames upper bits dropped.
    send(8'hF7);
    send(8'h11);
    send(8'h22);
    check("t5a_v", 32'(v_o), 32'h1);
    check("t5a_frames", 32'(frames_o), 32'h7);
    check("t5a_board", 32'(board_o), 32'h2211);
    handoff();

    // Same message as before, bubbles between words.
    send(8'h05);
    idle(2);
    send(8'hA5);
    check("t2_partial_board", 32'(board_o), 32'h22A5);
    idle(3);
    check("t2_bubble_v", 32'(v_o), 32'h0);
    check("t2_bubble_ready", 32'(ready_o), 32'h1);
    send(8'h3C);
    check("t2_v", 32'(v_o), 32'h1);
    check("t2_board", 32'(board_o), 32'h3CA5);
    check("t2_frames", 32'(frames_o), 32'h5);
    handoff();

    // Zero frame count passes through.
    send(8'h00);
    send(8'h00);
    send(8'h80);
    check("t5b_v", 32'(v_o), 32'h1);
    check("t5b_frames", 32'(frames_o), 32'h0);
    check("t5b_board", 32'(board_o), 32'h8000);
    handoff();

    // Reset mid-message.
    send(8'h05);
    send(8'h77);
    reset_i = 1'b0;
    #1;
    check("t4_v", 32'(v_o), 32'h0);
    check("t4_ready", 32'(ready_o), 32'h1);
    check("t4_board", 32'(board_o), 32'h0);
    check("t4_frames", 32'(frames_o), 32'h0);
    #1;
    reset_i = 1'b1;
    cyc();
    check("t4_post_v", 32'(v_o), 32'h0);
    send(8'h09);
    send(8'h12);
    check("t4_new_mid_v", 32'(v_o), 32'h0);
    send(8'h34);
    check("t4_new_v", 32'(v_o), 32'h1);
    check("t4_new_board", 32'(board_o), 32'h3412);
    check("t4_new_frames", 32'(frames_o), 32'h9);

    // Frames word offered during the handoff cycle.
    ready_i = 1'b1;
    v_i     = 1'b1;
    data_i  = 8'h02;
    #1;
`ifdef BSG_CGOL_DESER_BYPASS_EN
    check("t6_ready_in_handoff", 32'(ready_o), 32'h1);
    @(posedge clk_i);
    #1;
    ready_i = 1'b0;
    v_i     = 1'b0;
    check("t6_v_after", 32'(v_o), 32'h0);
    check("t6_frames_captured", 32'(frames_o), 32'h2);
`else
    check("t6_ready_in_handoff", 32'(ready_o), 32'h0);
    @(posedge clk_i);
    #1;
    ready_i = 1'b0;
    check("t6_v_after", 32'(v_o), 32'h0);
    check("t6_frames_not_yet", 32'(frames_o), 32'h9);
    check("t6_ready_after", 32'(ready_o), 32'h1);
    send(8'h02);
    check("t6_frames_captured", 32'(frames_o), 32'h2);
`endif
    send(8'hAB);
    check("t6_mid_v", 32'(v_o), 32'h0);
    send(8'hCD);
    check("t6_v", 32'(v_o), 32'h1);
    check("t6_board", 32'(board_o), 32'hCDAB);
    check("t6_frames", 32'(frames_o), 32'h2);
    handoff();
    check("t6_end_v", 32'(v_o), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
